// File: rtl/axi4_ram_slave.sv
// AXI4 burst RAM responder: single-ported word memory serving one INCR write or
// read burst at a time, with DECERR for addresses beyond the memory and SLVERR on wlast misuse.
module axi4_ram_slave #(
    parameter int BYTE_WIDTH = 2,
    parameter int A_WIDTH    = 32,
    parameter int MEM_AW     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [A_WIDTH-1:0]      awaddr,
    input  logic [7:0]              awlen,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic                    wlast,
    input  logic [8*BYTE_WIDTH-1:0] wdata,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [A_WIDTH-1:0]      araddr,
    input  logic [7:0]              arlen,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    rlast,
    output logic [8*BYTE_WIDTH-1:0] rdata,
    output logic [1:0]              rresp
);

    localparam int DW = 8 * BYTE_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WRESP = 3'd2,
        RPREP = 3'd3,
        RDATA = 3'd4
    } state_t;

    logic [DW-1:0]     r_mem [0:(1<<MEM_AW)-1];
    state_t            r_state;
    logic [MEM_AW-1:0] r_idx;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic              r_oor;
    logic              r_err;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_rvalid;
    logic              r_rlast;
    logic [DW-1:0]     r_rdata;
    logic [1:0]        r_rresp;

    logic              w_aw_hs;
    logic              w_ar_hs;
    logic              w_w_hs;
    logic              w_r_hs;
    logic              w_last_beat;
    logic              w_wlast_err;
    logic              w_aw_oor;
    logic              w_ar_oor;
    logic [MEM_AW-1:0] w_rd_idx;

    assign awready = (r_state == IDLE);
    assign arready = (r_state == IDLE) && !awvalid;
    assign wready  = (r_state == WDATA);

    assign w_aw_hs     = awvalid && awready;
    assign w_ar_hs     = arvalid && arready;
    assign w_w_hs      = wvalid && wready;
    assign w_r_hs      = r_rvalid && rready;
    assign w_last_beat = (r_cnt == r_len);
    assign w_wlast_err = (wlast != w_last_beat);
    assign w_aw_oor    = |awaddr[A_WIDTH-1:MEM_AW];
    assign w_ar_oor    = |araddr[A_WIDTH-1:MEM_AW];
    // Look one word ahead while a beat is being consumed so the next beat has no bubble.
    assign w_rd_idx    = w_r_hs ? (r_idx + MEM_AW'(1)) : r_idx;

    assign bvalid = r_bvalid;
    assign bresp  = r_bresp;
    assign rvalid = r_rvalid;
    assign rlast  = r_rlast;
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;

    // RAM write port; contents survive reset so a burst aborted by reset keeps its earlier beats.
    always_ff @(posedge clk) begin
        if (w_w_hs && !r_oor) begin
            r_mem[r_idx] <= wdata;
        end
    end

    // Transaction FSM with registered B and R channel outputs and registered RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_len    <= 8'd0;
            r_cnt    <= 8'd0;
            r_oor    <= 1'b0;
            r_err    <= 1'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aw_hs) begin
                        r_idx   <= awaddr[MEM_AW-1:0];
                        r_len   <= awlen;
                        r_oor   <= w_aw_oor;
                        r_cnt   <= 8'd0;
                        r_err   <= 1'b0;
                        r_state <= WDATA;
                    end else if (w_ar_hs) begin
                        r_idx   <= araddr[MEM_AW-1:0];
                        r_len   <= arlen;
                        r_oor   <= w_ar_oor;
                        r_cnt   <= 8'd0;
                        r_err   <= 1'b0;
                        r_state <= RPREP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WDATA: begin
                    if (w_w_hs) begin
                        r_idx <= r_idx + MEM_AW'(1);
                        if (w_wlast_err) begin
                            r_err <= 1'b1;
                        end
                        // Beat count, not wlast, decides where the burst ends.
                        if (w_last_beat) begin
                            r_state  <= WRESP;
                            r_bvalid <= 1'b1;
                            if (r_oor) begin
                                r_bresp <= RESP_DECERR;
                            end else if (r_err || w_wlast_err) begin
                                r_bresp <= RESP_SLVERR;
                            end else begin
                                r_bresp <= RESP_OKAY;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                WRESP: begin
                    if (bready) begin
                        r_bvalid <= 1'b0;
                        r_bresp  <= RESP_OKAY;
                        r_state  <= IDLE;
                    end
                end
                RPREP: begin
                    r_rdata  <= r_oor ? '0 : r_mem[w_rd_idx];
                    r_rresp  <= r_oor ? RESP_DECERR : RESP_OKAY;
                    r_rvalid <= 1'b1;
                    r_rlast  <= (r_len == 8'd0);
                    r_state  <= RDATA;
                end
                RDATA: begin
                    if (w_r_hs) begin
                        if (w_last_beat) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_rresp  <= RESP_OKAY;
                            r_state  <= IDLE;
                        end else begin
                            r_idx   <= r_idx + MEM_AW'(1);
                            r_cnt   <= r_cnt + 8'd1;
                            r_rlast <= (r_cnt + 8'd1 == r_len);
                            r_rdata <= r_oor ? '0 : r_mem[w_rd_idx];
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_ram_slave.sv
// Self-checking bench for axi4_ram_slave: directed scenarios plus randomized bursts
// compared against an array model of the memory and the response rules.
module tb_axi4_ram_slave;

    localparam int BW  = 2;
    localparam int AW  = 32;
    localparam int MAW = 8;
    localparam int DW  = 8 * BW;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [AW-1:0] awaddr  = '0;
    logic [7:0]    awlen   = 8'd0;
    logic          wvalid  = 1'b0;
    logic          wready;
    logic          wlast   = 1'b0;
    logic [DW-1:0] wdata   = '0;
    logic          bvalid;
    logic          bready  = 1'b0;
    logic [1:0]    bresp;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [AW-1:0] araddr  = '0;
    logic [7:0]    arlen   = 8'd0;
    logic          rvalid;
    logic          rready  = 1'b0;
    logic          rlast;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] wbuf    [0:255];
    logic [DW-1:0] rbuf    [0:255];
    logic          rlast_b [0:255];
    logic [1:0]    rresp_b [0:255];

    axi4_ram_slave #(.BYTE_WIDTH(BW), .A_WIDTH(AW), .MEM_AW(MAW)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic model_write(input logic [31:0] a, input int n);
        if (a[31:8] == 24'd0) begin
            for (int i = 0; i < n; i++) ref_mem[(int'(a[7:0]) + i) % 256] = wbuf[i];
        end
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] len, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        awaddr = a; awlen = len; awvalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (awready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] len, output int hs, output bit ok);
        ok = 1'b0; hs = -100;
        @(negedge clk);
        araddr = a; arlen = len; arvalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (arready) begin ok = 1'b1; hs = cyc; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic do_w(input int n, input int last_at, output bit ok);
        bit got;
        ok = 1'b1;
        for (int b = 0; b < n; b++) begin
            got = 1'b0;
            @(negedge clk);
            wvalid = 1'b1; wdata = wbuf[b]; wlast = (b == last_at);
            for (int i = 0; i < 64; i++) begin
                if (wready) begin got = 1'b1; break; end
                @(negedge clk);
            end
            if (!got) begin ok = 1'b0; break; end
            @(posedge clk);
            #1 wvalid = 1'b0; wlast = 1'b0;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b(output logic [1:0] resp, output bit ok);
        ok = 1'b0; resp = 2'bxx;
        @(negedge clk);
        bready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (bvalid) begin resp = bresp; ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 bready = 1'b0;
    endtask

    // Collects beats until rlast is accepted; rready follows pat bit k on the k-th valid cycle.
    task automatic do_r(input logic [31:0] pat, output int nb, output int first_cyc, output int unstable);
        bit held, done;
        int k;
        logic [DW-1:0] hd; logic hl; logic [1:0] hr;
        nb = 0; first_cyc = -1; unstable = 0; held = 1'b0; done = 1'b0; k = 0;
        hd = '0; hl = 1'b0; hr = 2'b00;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (rvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (held && (rdata !== hd || rlast !== hl || rresp !== hr)) unstable++;
                rready = (k < 32) ? pat[k] : 1'b1;
                k++;
            end else begin
                rready = 1'b0;
            end
            if (rvalid && rready) begin
                rbuf[nb] = rdata; rlast_b[nb] = rlast; rresp_b[nb] = rresp;
                nb++; held = 1'b0;
                done = rlast || (nb >= 256);
            end else if (rvalid) begin
                held = 1'b1; hd = rdata; hl = rlast; hr = rresp;
            end
            if (done) break;
        end
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bvalid, rvalid, rlast, bresp, rresp, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got bv=%b rv=%b rl=%b br=%b rr=%b rd=%h want all zero", bvalid, rvalid, rlast, bresp, rresp, rdata);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({awready, arready, wready} !== 3'b110) begin
            bad++;
            $display("FAIL reset_ready: got aw/ar/w=%b want 110", {awready, arready, wready});
        end
    endtask

    task automatic test_fill();
        bit o1, o2, o3, o4; logic [1:0] resp; int hs, fc, nb, un;
        for (int i = 0; i < 256; i++) wbuf[i] = DW'($urandom);
        do_aw(32'h0, 8'd255, o1); do_w(256, 255, o2); do_b(resp, o3);
        model_write(32'h0, 256);
        total++;
        if (!(o1 && o2 && o3) || resp !== 2'b00) begin
            bad++; $display("FAIL fill_bresp: got ok=%b resp=%b want ok=1 resp=00", o1 && o2 && o3, resp);
        end
        do_ar(32'h0, 8'd255, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (!o4 || nb != 256) begin bad++; $display("FAIL fill_beats: got %0d want 256", nb); end
        for (int i = 0; i < 256; i++) begin
            total++;
            if ({rbuf[i], rlast_b[i], rresp_b[i]} !== {ref_mem[i], (i == 255), 2'b00}) begin
                bad++; $display("FAIL fill_rd beat %0d: got d=%h l=%b r=%b want d=%h l=%b r=00", i, rbuf[i], rlast_b[i], rresp_b[i], ref_mem[i], (i == 255));
            end
        end
    endtask

    task automatic test_basic();
        bit o1, o2, o3, o4; logic [1:0] resp; int hs, fc, nb, un; logic [DW-1:0] e;
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(16'h1111 * (i + 1));
        do_aw(32'h10, 8'd3, o1); do_w(4, 3, o2);
        total++;
        if ({wready, bvalid} !== 2'b01) begin
            bad++; $display("FAIL basic_after_w: got wready/bvalid=%b want 01", {wready, bvalid});
        end
        do_b(resp, o3);
        model_write(32'h10, 4);
        total++;
        if (!(o1 && o2 && o3) || resp !== 2'b00) begin
            bad++; $display("FAIL basic_bresp: got ok=%b resp=%b want ok=1 resp=00", o1 && o2 && o3, resp);
        end
        do_ar(32'h10, 8'd3, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (!o4 || fc - hs != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", fc - hs); end
        total++;
        if (nb != 4) begin bad++; $display("FAIL basic_beats: got %0d want 4", nb); end
        for (int i = 0; i < 4; i++) begin
            e = DW'(16'h1111 * (i + 1));
            total++;
            if ({rbuf[i], rlast_b[i], rresp_b[i]} !== {e, (i == 3), 2'b00}) begin
                bad++; $display("FAIL basic_rd beat %0d: got d=%h l=%b r=%b want d=%h l=%b r=00", i, rbuf[i], rlast_b[i], rresp_b[i], e, (i == 3));
            end
        end
    endtask

    task automatic test_wrap();
        bit o1, o2, o3, o4; logic [1:0] resp; int hs, fc, nb, un;
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB;
        do_aw(32'hFF, 8'd1, o1); do_w(2, 1, o2); do_b(resp, o3);
        model_write(32'hFF, 2);
        total++;
        if (!(o1 && o2 && o3) || resp !== 2'b00) begin
            bad++; $display("FAIL wrap_bresp: got ok=%b resp=%b want ok=1 resp=00", o1 && o2 && o3, resp);
        end
        do_ar(32'hFF, 8'd0, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (!o4 || nb != 1 || rbuf[0] !== 16'hAAAA) begin
            bad++; $display("FAIL wrap_rd_ff: got n=%0d d=%h want n=1 d=aaaa", nb, rbuf[0]);
        end
        do_ar(32'h00, 8'd0, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (!o4 || nb != 1 || rbuf[0] !== 16'hBBBB) begin
            bad++; $display("FAIL wrap_rd_00: got n=%0d d=%h want n=1 d=bbbb", nb, rbuf[0]);
        end
        do_ar(32'hFF, 8'd1, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (!o4 || nb != 2 || rbuf[0] !== 16'hAAAA || rbuf[1] !== 16'hBBBB || rlast_b[1] !== 1'b1) begin
            bad++; $display("FAIL wrap_rd_burst: got n=%0d d0=%h d1=%h want n=2 d0=aaaa d1=bbbb", nb, rbuf[0], rbuf[1]);
        end
    endtask

    task automatic test_priority();
        bit o2, o3, o4; logic [1:0] resp; int hs, fc, nb, un, cb;
        wbuf[0] = DW'($urandom); wbuf[1] = DW'($urandom);
        @(negedge clk);
        awaddr = 32'h20; awlen = 8'd1; awvalid = 1'b1;
        araddr = 32'h20; arlen = 8'd1; arvalid = 1'b1;
        #1;
        total++;
        if ({awready, arready} !== 2'b10) begin
            bad++; $display("FAIL prio_ready: got aw/ar=%b want 10", {awready, arready});
        end
        @(posedge clk);
        #1 awvalid = 1'b0;
        total++;
        if (arready !== 1'b0) begin bad++; $display("FAIL prio_ar_during_w: got %b want 0", arready); end
        do_w(2, 1, o2);
        @(negedge clk);
        total++;
        if ({arready, bvalid} !== 2'b01) begin
            bad++; $display("FAIL prio_ar_during_b: got ar/bv=%b want 01", {arready, bvalid});
        end
        do_b(resp, o3);
        model_write(32'h20, 2);
        cb = cyc;
        do_ar(32'h20, 8'd1, hs, o4);
        total++;
        if (!(o2 && o3 && o4) || resp !== 2'b00 || hs != cb) begin
            bad++; $display("FAIL prio_order: got resp=%b ar_at=%0d want resp=00 ar_at=%0d", resp, hs, cb);
        end
        do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (nb != 2 || rbuf[0] !== ref_mem[8'h20] || rbuf[1] !== ref_mem[8'h21]) begin
            bad++; $display("FAIL prio_rd: got n=%0d %h %h want n=2 %h %h", nb, rbuf[0], rbuf[1], ref_mem[8'h20], ref_mem[8'h21]);
        end
    endtask

    task automatic test_errors();
        bit o1, o2, o3, o4; logic [1:0] resp; int hs, fc, nb, un;
        for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom);
        do_aw(32'h30, 8'd3, o1); do_w(4, 1, o2);
        total++;
        if (!(o1 && o2) || wready !== 1'b0) begin
            bad++; $display("FAIL err_beats: got ok=%b wready=%b want ok=1 wready=0", o1 && o2, wready);
        end
        do_b(resp, o3);
        model_write(32'h30, 4);
        total++;
        if (!o3 || resp !== 2'b10) begin bad++; $display("FAIL err_early_wlast: got %b want 10", resp); end
        do_aw(32'h40, 8'd1, o1); do_w(2, 5, o2); do_b(resp, o3);
        model_write(32'h40, 2);
        total++;
        if (!(o1 && o2 && o3) || resp !== 2'b10) begin bad++; $display("FAIL err_no_wlast: got %b want 10", resp); end
        do_ar(32'h30, 8'd3, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (!o4 || rbuf[i] !== ref_mem[8'h30 + i] || rresp_b[i] !== 2'b00) begin
                bad++; $display("FAIL err_data_kept beat %0d: got %h/%b want %h/00", i, rbuf[i], rresp_b[i], ref_mem[8'h30 + i]);
            end
        end
        wbuf[0] = ~ref_mem[0];
        do_aw(32'h100, 8'd0, o1); do_w(1, 0, o2); do_b(resp, o3);
        total++;
        if (!(o1 && o2 && o3) || resp !== 2'b11) begin bad++; $display("FAIL err_decerr_w: got %b want 11", resp); end
        do_ar(32'h100, 8'd0, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (!o4 || nb != 1 || {rbuf[0], rresp_b[0], rlast_b[0]} !== {16'h0000, 2'b11, 1'b1}) begin
            bad++; $display("FAIL err_decerr_r: got n=%0d d=%h r=%b l=%b want n=1 d=0000 r=11 l=1", nb, rbuf[0], rresp_b[0], rlast_b[0]);
        end
        do_ar(32'h0, 8'd0, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (!o4 || rbuf[0] !== ref_mem[0]) begin
            bad++; $display("FAIL err_oor_write_suppressed: got %h want %h", rbuf[0], ref_mem[0]);
        end
    endtask

    task automatic test_backpressure();
        bit o1, o2, o3, o4; logic [1:0] resp; int hs, fc, nb, un;
        for (int i = 0; i < 3; i++) wbuf[i] = DW'($urandom);
        do_aw(32'h50, 8'd2, o1); do_w(3, 2, o2); do_b(resp, o3);
        model_write(32'h50, 3);
        do_ar(32'h50, 8'd2, hs, o4); do_r(32'h0000_0019, nb, fc, un);
        total++;
        if (!(o1 && o2 && o3 && o4) || nb != 3 || un != 0) begin
            bad++; $display("FAIL bp_count: got beats=%0d unstable=%0d want beats=3 unstable=0", nb, un);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({rbuf[i], rlast_b[i]} !== {ref_mem[8'h50 + i], (i == 2)}) begin
                bad++; $display("FAIL bp_rd beat %0d: got %h/%b want %h/%b", i, rbuf[i], rlast_b[i], ref_mem[8'h50 + i], (i == 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit o1, o2, o4; int hs, fc, nb, un;
        for (int i = 0; i < 8; i++) wbuf[i] = DW'($urandom);
        do_aw(32'h60, 8'd7, o1); do_w(1, -1, o2);
        @(negedge clk);
        wvalid = 1'b1; wdata = wbuf[1]; wlast = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bvalid, rvalid, rlast, bresp, rresp, rdata, wready} !== '0) begin
            bad++; $display("FAIL rstmid_outputs: got bv=%b rv=%b rl=%b br=%b rr=%b rd=%h wr=%b want all zero", bvalid, rvalid, rlast, bresp, rresp, rdata, wready);
        end
        @(negedge clk);
        wvalid = 1'b0; rst = 1'b0;
        #1;
        total++;
        if (!(o1 && o2) || awready !== 1'b1) begin bad++; $display("FAIL rstmid_awready: got %b want 1", awready); end
        repeat (3) @(negedge clk);
        total++;
        if (bvalid !== 1'b0) begin bad++; $display("FAIL rstmid_no_b: got %b want 0", bvalid); end
        ref_mem[8'h60] = wbuf[0];
        do_ar(32'h60, 8'd1, hs, o4); do_r(32'hFFFF_FFFF, nb, fc, un);
        total++;
        if (!o4 || nb != 2 || rbuf[0] !== ref_mem[8'h60] || rbuf[1] !== ref_mem[8'h61]) begin
            bad++; $display("FAIL rstmid_mem: got n=%0d %h %h want n=2 %h %h", nb, rbuf[0], rbuf[1], ref_mem[8'h60], ref_mem[8'h61]);
        end
    endtask

    task automatic test_random();
        bit o1, o2, o3, o4, oor; logic [1:0] resp, eresp; int hs, fc, nb, un, len, last_at;
        logic [31:0] a; logic [DW-1:0] e;
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(15);
            oor = ($urandom_range(4) == 0);
            a = {24'd0, 8'($urandom_range(255))};
            if (oor) a[15:8] = 8'($urandom_range(255, 1));
            last_at = len;
            if ($urandom_range(3) == 0) last_at = $urandom_range(len + 1);
            for (int i = 0; i <= len; i++) wbuf[i] = DW'($urandom);
            eresp = oor ? 2'b11 : ((last_at != len) ? 2'b10 : 2'b00);
            do_aw(a, 8'(len), o1); do_w(len + 1, last_at, o2); do_b(resp, o3);
            model_write(a, len + 1);
            total++;
            if (!(o1 && o2 && o3) || resp !== eresp) begin
                bad++; $display("FAIL rand_bresp it %0d: got ok=%b resp=%b want ok=1 resp=%b", it, o1 && o2 && o3, resp, eresp);
            end
            len = $urandom_range(15);
            oor = ($urandom_range(5) == 0);
            a = {24'd0, 8'($urandom_range(255))};
            if (oor) a[31:24] = 8'($urandom_range(255, 1));
            do_ar(a, 8'(len), hs, o4); do_r($urandom, nb, fc, un);
            total++;
            if (!o4 || nb != len + 1 || un != 0 || fc - hs != 2) begin
                bad++; $display("FAIL rand_rd it %0d: got beats=%0d unstable=%0d lat=%0d want beats=%0d unstable=0 lat=2", it, nb, un, fc - hs, len + 1);
            end
            for (int i = 0; i <= len; i++) begin
                e = oor ? '0 : ref_mem[(int'(a[7:0]) + i) % 256];
                total++;
                if ({rbuf[i], rlast_b[i], rresp_b[i]} !== {e, (i == len), (oor ? 2'b11 : 2'b00)}) begin
                    bad++; $display("FAIL rand_beat it %0d beat %0d: got d=%h l=%b r=%b want d=%h l=%b r=%b", it, i, rbuf[i], rlast_b[i], rresp_b[i], e, (i == len), (oor ? 2'b11 : 2'b00));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_wrap();
        test_priority();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
